// File: rtl/timer_multi_if.sv
// Register-bus interface for timer_multi: one request/response channel,
// byte-addressed, single-cycle ready/error response.
interface timer_multi_if;
   logic [31:0] timer_address;
   logic [31:0] timer_wdata;
   logic [3:0]  timer_wsel;
   logic        timer_valid;
   logic [31:0] timer_rdata;
   logic        timer_ready;
   logic        timer_error;

   // Bus initiator: issues requests, receives the response.
   modport master (
      output timer_address,
      output timer_wdata,
      output timer_wsel,
      output timer_valid,
      input  timer_rdata,
      input  timer_ready,
      input  timer_error
   );

   // Timer block: decodes requests, returns registered responses.
   modport slave (
      input  timer_address,
      input  timer_wdata,
      input  timer_wsel,
      input  timer_valid,
      output timer_rdata,
      output timer_ready,
      output timer_error
   );
endinterface

// File: rtl/timer_multi.sv
// Multi-channel 64-bit machine timer: prescaled mtime counter, N_CH compare
// channels (one-shot or periodic), sticky W1C status and masked interrupts.
module timer_multi #(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned PRESC_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   timer_multi_if.slave    bus,
   output logic [N_CH-1:0] timer_irq,
   output logic            xint_mtip
);

   // Channel windows start at 0x40, i.e. address nibble [7:4] == 4.
   localparam int unsigned CH_BASE_NIB = 4;

   localparam logic [2:0] G_MTIME_LO = 3'd0;
   localparam logic [2:0] G_MTIME_HI = 3'd1;
   localparam logic [2:0] G_PRESC    = 3'd2;
   localparam logic [2:0] G_CTRL     = 3'd3;
   localparam logic [2:0] G_STATUS   = 3'd4;
   localparam logic [2:0] G_IRQEN    = 3'd5;

   localparam logic [1:0] C_CMP_LO   = 2'd0;
   localparam logic [1:0] C_CMP_HI   = 2'd1;
   localparam logic [1:0] C_MODE     = 2'd2;
   localparam logic [1:0] C_PERIOD   = 2'd3;

   // Architectural state
   logic [63:0]        mtime;
   logic [PRESC_W-1:0] pre_cnt;
   logic [PRESC_W-1:0] presc;
   logic               ctrl_en;
   logic [N_CH-1:0]    status;
   logic [N_CH-1:0]    irqen;
   logic [63:0]        cmp    [N_CH];
   logic [31:0]        period [N_CH];
   logic [N_CH-1:0]    mode_en;
   logic [N_CH-1:0]    mode_per;

   // Decode
   logic [7:0]  addr_lo;
   logic [2:0]  goff;
   logic [1:0]  coff;
   logic [3:0]  ch_idx;
   logic        glob_sel;
   logic        ch_sel;
   logic        addr_ok;
   logic        is_write;
   logic        wsel_ok;
   logic        accept;
   logic        acc_ok;
   logic        acc_err;
   logic        wr;
   logic        rd_en;

   logic        wr_mlo, wr_mhi, wr_presc, wr_ctrl, wr_status, wr_irqen;
   logic [N_CH-1:0] ch_hit;
   logic [N_CH-1:0] wr_cmp_lo, wr_cmp_hi, wr_mode, wr_period;

   logic [31:0]     rd_val;
   logic [N_CH-1:0] match;
   logic [N_CH-1:0] status_clr;
   logic            tick;

   assign addr_lo  = bus.timer_address[7:0];
   assign goff     = addr_lo[4:2];
   assign coff     = addr_lo[3:2];
   assign ch_idx   = addr_lo[7:4] - 4'(CH_BASE_NIB);
   assign glob_sel = (addr_lo[7:5] == 3'd0) && (goff <= G_IRQEN);
   assign ch_sel   = (addr_lo[7:6] != 2'd0) && (32'(ch_idx) < N_CH);
   assign addr_ok  = (addr_lo[1:0] == 2'b00) && (glob_sel || ch_sel);
   assign is_write = |bus.timer_wsel;
   assign wsel_ok  = !is_write || (bus.timer_wsel == 4'hF);

   // A new request is taken only when no response is currently showing.
   assign accept   = bus.timer_valid && !bus.timer_ready && !bus.timer_error;
   assign acc_ok   = accept && addr_ok && wsel_ok;
   assign acc_err  = accept && !(addr_ok && wsel_ok);
   assign wr       = acc_ok && is_write;
   assign rd_en    = acc_ok && !is_write;

   assign wr_mlo    = wr && glob_sel && (goff == G_MTIME_LO);
   assign wr_mhi    = wr && glob_sel && (goff == G_MTIME_HI);
   assign wr_presc  = wr && glob_sel && (goff == G_PRESC);
   assign wr_ctrl   = wr && glob_sel && (goff == G_CTRL);
   assign wr_status = wr && glob_sel && (goff == G_STATUS);
   assign wr_irqen  = wr && glob_sel && (goff == G_IRQEN);

   assign status_clr = wr_status ? bus.timer_wdata[N_CH-1:0] : '0;
   assign tick       = ctrl_en && (pre_cnt == presc);

   // Per-channel write strobes and compare results
   always_comb begin
      ch_hit    = '0;
      wr_cmp_lo = '0;
      wr_cmp_hi = '0;
      wr_mode   = '0;
      wr_period = '0;
      match     = '0;
      for (int k = 0; k < int'(N_CH); k++) begin
         ch_hit[k]    = ch_sel && (ch_idx == 4'(k));
         wr_cmp_lo[k] = wr && ch_hit[k] && (coff == C_CMP_LO);
         wr_cmp_hi[k] = wr && ch_hit[k] && (coff == C_CMP_HI);
         wr_mode[k]   = wr && ch_hit[k] && (coff == C_MODE);
         wr_period[k] = wr && ch_hit[k] && (coff == C_PERIOD);
         match[k]     = mode_en[k] && (mtime >= cmp[k]);
      end
   end

   // Read data mux on current register values
   always_comb begin
      rd_val = '0;
      if (glob_sel) begin
         case (goff)
            G_MTIME_LO: rd_val = mtime[31:0];
            G_MTIME_HI: rd_val = mtime[63:32];
            G_PRESC:    rd_val = 32'(presc);
            G_CTRL:     rd_val = {31'd0, ctrl_en};
            G_STATUS:   rd_val = 32'(status);
            G_IRQEN:    rd_val = 32'(irqen);
            default:    rd_val = '0;
         endcase
      end else begin
         for (int k = 0; k < int'(N_CH); k++) begin
            if (ch_hit[k]) begin
               case (coff)
                  C_CMP_LO: rd_val = cmp[k][31:0];
                  C_CMP_HI: rd_val = cmp[k][63:32];
                  C_MODE:   rd_val = {30'd0, mode_per[k], mode_en[k]};
                  default:  rd_val = period[k];
               endcase
            end
         end
      end
   end

   // Prescaler, mtime and global control registers; bus writes beat the tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime   <= '0;
         pre_cnt <= '0;
         presc   <= '0;
         ctrl_en <= 1'b1;
         irqen   <= '0;
         status  <= '0;
      end else begin
         if (wr_presc) begin
            presc   <= bus.timer_wdata[PRESC_W-1:0];
            pre_cnt <= '0;
         end else if (tick) begin
            pre_cnt <= '0;
         end else if (ctrl_en) begin
            pre_cnt <= pre_cnt + PRESC_W'(1);
         end

         if (wr_ctrl) begin
            ctrl_en <= bus.timer_wdata[0];
         end

         if (wr_mlo) begin
            mtime[31:0] <= bus.timer_wdata;
         end else if (wr_mhi) begin
            mtime[63:32] <= bus.timer_wdata;
         end else if (tick) begin
            mtime <= mtime + 64'd1;
         end

         if (wr_irqen) begin
            irqen <= bus.timer_wdata[N_CH-1:0];
         end

         // A new match wins over a simultaneous W1C of the same bit.
         status <= (status & ~status_clr) | match;
      end
   end

   // Compare channels: bus writes to CMP/MODE override the automatic update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_en  <= '0;
         mode_per <= '0;
         for (int k = 0; k < int'(N_CH); k++) begin
            cmp[k]    <= '1;
            period[k] <= '0;
         end
      end else begin
         for (int k = 0; k < int'(N_CH); k++) begin
            if (wr_cmp_lo[k] || wr_cmp_hi[k] || wr_mode[k]) begin
               if (wr_cmp_lo[k]) begin
                  cmp[k][31:0] <= bus.timer_wdata;
               end
               if (wr_cmp_hi[k]) begin
                  cmp[k][63:32] <= bus.timer_wdata;
               end
               if (wr_mode[k]) begin
                  mode_en[k]  <= bus.timer_wdata[0];
                  mode_per[k] <= bus.timer_wdata[1];
               end
            end else if (match[k]) begin
               if (mode_per[k]) begin
                  cmp[k] <= cmp[k] + {32'd0, period[k]};
               end else begin
                  mode_en[k] <= 1'b0;
               end
            end

            if (wr_period[k]) begin
               period[k] <= bus.timer_wdata;
            end
         end
      end
   end

   // Bus response: one-cycle ready or error pulse, read data alongside ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.timer_ready <= 1'b0;
         bus.timer_error <= 1'b0;
         bus.timer_rdata <= '0;
      end else begin
         bus.timer_ready <= acc_ok;
         bus.timer_error <= acc_err;
         if (rd_en) begin
            bus.timer_rdata <= rd_val;
         end
      end
   end

   // Masked interrupts, one stage behind STATUS
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_irq <= '0;
         xint_mtip <= 1'b0;
      end else begin
         timer_irq <= status & irqen;
         xint_mtip <= |(status & irqen);
      end
   end

endmodule
